program_loader: RTL

//  Boot-time controller that fills the instruction memory from a byte stream (UART RX or debug

---
 rtl/loader_pkg.sv | 29 ++
 rtl/byte_assembler.sv | 45 ++++
 rtl/program_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
//
// Contents:
//   state_t         loader FSM encoding (IDLE/LEN/DATA/DONE/ERROR, 3 bits)
//   LEN_BYTES       number of bytes in the little-endian image length header
//   BYTES_PER_WORD  bytes assembled into one program memory word
//   cnt_width()     bits needed for a counter that runs 0 .. n-1
//   BYTE_IDX_W      width of the byte index inside a word
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // A counter that must reach n-1 needs clog2(n) bits; never less than 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BYTE_IDX_W = cnt_width(BYTES_PER_WORD);

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - little-endian byte to 32-bit word assembler
//
// Ports:
//   clk         in   1           rising-edge clock
//   reset       in   1           synchronous reset, active low
//   clear       in   1           discard any partial word (wins over accept)
//   accept      in   1           byte_in is taken this cycle
//   byte_in     in   8           incoming byte
//   byte_index  out  BYTE_IDX_W  position the next accepted byte will occupy
//   word_valid  out  1           accept of the last byte of a word this cycle
//   word        out  32          {byte_in, three earlier bytes}; complete when word_valid
module byte_assembler
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_in,
    output logic [BYTE_IDX_W-1:0] byte_index,
    output logic                  word_valid,
    output logic [31:0]           word
);

    // Only the three earlier bytes are stored; the fourth comes straight from
    // byte_in so the finished word is available in the cycle it completes.
    logic [23:0]           shift_reg;
    logic [BYTE_IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            idx       <= '0;
            shift_reg <= '0;
        end else if (accept) begin
            // Newest byte enters at the top, so byte0 ends up in [7:0].
            shift_reg <= {byte_in, shift_reg[23:8]};
            idx       <= idx + 1'b1;
        end
    end

    assign byte_index = idx;
    assign word       = {byte_in, shift_reg};
    assign word_valid = accept && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader filling program memory from a byte stream
//
// Ports:
//   clk          in   1           rising-edge clock
//   reset        in   1           synchronous reset, active low
//   Start        in   1           pulse; arms a load from IDLE or ERROR
//   ByteIn       in   8           stream byte
//   ByteValid    in   1           ByteIn is valid
//   ByteReady    out  1           byte accepted when ByteValid is also high
//   MemWrite     out  1           one-cycle program memory write strobe
//   MemAddress   out  DATA_WIDTH  word-aligned byte address of the write
//   MemData      out  DATA_WIDTH  write data
//   CpuHold      out  1           core stalled while not IDLE
//   Busy         out  1           in LEN or DATA
//   Done         out  1           one-cycle pulse when the image is complete
//   Error        out  1           sticky until the next Start
//   WordsLoaded  out  16          words written in the current load
module program_loader
    import loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH   = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS   = '0,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemData,
    output logic                  CpuHold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [15:0]           WordsLoaded
);

    localparam int TIMER_W = cnt_width(TIMEOUT_CYCLES);

    state_t                state;
    state_t                next_state;
    logic [TIMER_W-1:0]    timer;
    logic [15:0]           n_words;

    logic                  accept;
    logic                  start_load;
    logic                  len_done;
    logic                  len_bad;
    logic                  word_done;
    logic                  timed_out;
    logic                  last_written;
    logic                  asm_clear;
    logic                  loading;

    logic [BYTE_IDX_W-1:0] byte_index;
    logic                  word_valid;
    logic [31:0]           word;

    assign loading    = (state == ST_LEN) || (state == ST_DATA);
    assign accept     = ByteValid && ByteReady;
    assign start_load = Start && ((state == ST_IDLE) || (state == ST_ERROR));

    // The length header reuses the assembler: after two bytes the top half of
    // the assembled word is {byte1, byte0}, i.e. N little-endian.
    assign len_done  = (state == ST_LEN) && accept &&
                       (byte_index == BYTE_IDX_W'(LEN_BYTES - 1));
    assign len_bad   = (word[31:16] == 16'd0) || (word[31:16] > 16'(MEMORY_DEPTH));
    assign word_done = (state == ST_DATA) && word_valid;

    // A byte arriving on the final idle cycle still counts as activity.
    assign timed_out    = (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) && !accept;
    assign last_written = MemWrite && (WordsLoaded == n_words);

    // Drop the header bytes before data, and any stale partial word on a new load.
    assign asm_clear = start_load || len_done;

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .accept     (accept),
        .byte_in    (ByteIn),
        .byte_index (byte_index),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_load) next_state = ST_LEN;
            end
            ST_LEN: begin
                if (len_done)       next_state = len_bad ? ST_ERROR : ST_DATA;
                else if (timed_out) next_state = ST_ERROR;
            end
            ST_DATA: begin
                // Leave only once the final word's write strobe is on the bus.
                if (last_written)   next_state = ST_DONE;
                else if (timed_out) next_state = ST_ERROR;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (start_load) next_state = ST_LEN;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ByteReady = 1'b0;
        CpuHold   = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state)
            ST_LEN, ST_DATA: begin
                ByteReady = 1'b1;
                CpuHold   = 1'b1;
                Busy      = 1'b1;
            end
            ST_DONE: begin
                CpuHold = 1'b1;
                Done    = 1'b1;
            end
            ST_ERROR: begin
                CpuHold = 1'b1;
                Error   = 1'b1;
            end
            default: begin
                CpuHold = 1'b0;
            end
        endcase
    end

    // Write port, word count, length and idle timer
    always_ff @(posedge clk) begin
        if (!reset) begin
            MemWrite    <= 1'b0;
            MemAddress  <= '0;
            MemData     <= '0;
            WordsLoaded <= '0;
            n_words     <= '0;
            timer       <= '0;
        end else begin
            MemWrite <= word_done;
            if (word_done) begin
                MemAddress  <= BASE_ADDRESS + (DATA_WIDTH'(WordsLoaded) << 2);
                MemData     <= DATA_WIDTH'(word);
                WordsLoaded <= WordsLoaded + 16'd1;
            end else if (start_load) begin
                WordsLoaded <= '0;
            end

            if (len_done) begin
                n_words <= word[31:16];
            end

            if (loading && !accept) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule
